// File: rtl/fp_norm_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_norm_pipe
//  Description : Two-stage valid/ready post-add normaliser. It turns a signed
//                raw significand sum into sign, magnitude, exponent, sticky
//                and zero/underflow/overflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_norm_pipe #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W+1:0] in_sig,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [MANT_W-1:0] out_sig,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sticky,
    output logic              out_zero,
    output logic              out_uf,
    output logic              out_of
);

    localparam int c_W  = MANT_W + 2;
    localparam int c_PW = $clog2(c_W);
    localparam int c_EW = EXP_W + 2;
    localparam logic [c_PW-1:0]        c_TARGET  = c_PW'(MANT_W - 1);
    localparam logic signed [c_EW-1:0] c_EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s1_load;
    logic w_s2_load;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // ------------------------------------------------------------------
    // Stage 1: magnitude and leading-one position
    // ------------------------------------------------------------------
    logic            w_in_sign;
    logic [c_W-1:0]  w_in_mag;
    logic [c_PW-1:0] w_in_p;

    assign w_in_sign = in_sig[c_W-1];
    // The most negative input negates to 2^(MANT_W+1), which still fits unsigned.
    assign w_in_mag  = w_in_sign ? (-in_sig) : in_sig;

    always_comb begin
        w_in_p = '0;
        for (int i = 0; i < c_W; i++) begin
            if (w_in_mag[i]) begin
                w_in_p = c_PW'(i);
            end
        end
    end

    logic             r_s1_sign;
    logic [c_W-1:0]   r_s1_mag;
    logic [c_PW-1:0]  r_s1_p;
    logic [EXP_W-1:0] r_s1_exp;
    logic             r_s1_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_mag   <= '0;
            r_s1_p     <= '0;
            r_s1_exp   <= '0;
            r_s1_zero  <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= w_in_sign;
                r_s1_mag  <= w_in_mag;
                r_s1_p    <= w_in_p;
                r_s1_exp  <= in_exp;
                r_s1_zero <= (w_in_mag == '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: shift to put the leading one at MANT_W-1, adjust exponent
    // ------------------------------------------------------------------
    logic                     w_right;
    logic [c_PW-1:0]          w_rsh;
    logic [c_PW-1:0]          w_lsh;
    logic [c_W-1:0]           w_mask;
    logic [MANT_W-1:0]        w_sig_norm;
    logic                     w_sticky;
    logic signed [c_EW-1:0]   w_amt_ext;
    logic signed [c_EW-1:0]   w_exp_ext;
    logic signed [c_EW-1:0]   w_exp_adj;
    logic                     w_uf;
    logic                     w_of;

    assign w_right    = (r_s1_p > c_TARGET);
    assign w_rsh      = r_s1_p - c_TARGET;
    assign w_lsh      = c_TARGET - r_s1_p;
    assign w_mask     = (c_W'(1) << w_rsh) - c_W'(1);
    assign w_sig_norm = w_right ? MANT_W'(r_s1_mag >> w_rsh) : MANT_W'(r_s1_mag << w_lsh);
    assign w_sticky   = w_right && (|(r_s1_mag & w_mask));
    assign w_amt_ext  = {{(c_EW-c_PW){1'b0}}, (w_right ? w_rsh : w_lsh)};
    assign w_exp_ext  = {2'b00, r_s1_exp};
    assign w_exp_adj  = w_right ? (w_exp_ext + w_amt_ext) : (w_exp_ext - w_amt_ext);
    assign w_uf       = w_exp_adj[c_EW-1] || (w_exp_adj == '0);
    assign w_of       = !w_exp_adj[c_EW-1] && (w_exp_adj >= c_EXP_MAX);

    logic              w_res_sign;
    logic [MANT_W-1:0] w_res_sig;
    logic [EXP_W-1:0]  w_res_exp;
    logic              w_res_sticky;
    logic              w_res_zero;
    logic              w_res_uf;
    logic              w_res_of;

    // Flag priority: zero over underflow over overflow.
    always_comb begin
        w_res_sign   = r_s1_sign;
        w_res_sig    = w_sig_norm;
        w_res_exp    = w_exp_adj[EXP_W-1:0];
        w_res_sticky = w_sticky;
        w_res_zero   = 1'b0;
        w_res_uf     = 1'b0;
        w_res_of     = 1'b0;
        if (r_s1_zero) begin
            w_res_sign   = 1'b0;
            w_res_sig    = '0;
            w_res_exp    = '0;
            w_res_sticky = 1'b0;
            w_res_zero   = 1'b1;
        end else if (w_uf) begin
            w_res_sig = '0;
            w_res_exp = '0;
            w_res_uf  = 1'b1;
        end else if (w_of) begin
            w_res_sig = '0;
            w_res_exp = '1;
            w_res_of  = 1'b1;
        end
    end

    logic              r_out_sign;
    logic [MANT_W-1:0] r_out_sig;
    logic [EXP_W-1:0]  r_out_exp;
    logic              r_out_sticky;
    logic              r_out_zero;
    logic              r_out_uf;
    logic              r_out_of;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_out_sign   <= 1'b0;
            r_out_sig    <= '0;
            r_out_exp    <= '0;
            r_out_sticky <= 1'b0;
            r_out_zero   <= 1'b0;
            r_out_uf     <= 1'b0;
            r_out_of     <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_sign   <= w_res_sign;
                r_out_sig    <= w_res_sig;
                r_out_exp    <= w_res_exp;
                r_out_sticky <= w_res_sticky;
                r_out_zero   <= w_res_zero;
                r_out_uf     <= w_res_uf;
                r_out_of     <= w_res_of;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_sign   = r_out_sign;
    assign out_sig    = r_out_sig;
    assign out_exp    = r_out_exp;
    assign out_sticky = r_out_sticky;
    assign out_zero   = r_out_zero;
    assign out_uf     = r_out_uf;
    assign out_of     = r_out_of;

endmodule
`default_nettype wire
